// File: rtl/shift_sequencer_if.sv
// Request/result bundle for shift_sequencer.
// The master drives the shift request; the slave returns status and the held result.
interface shift_sequencer_if;
    logic        Start;
    logic [1:0]  Sh;
    logic [7:0]  ShAmt8;
    logic [31:0] ShIn;
    logic        CFlagIn;
    logic        Busy;
    logic        Done;
    logic [31:0] ShOut;
    logic        CarryOut;

    modport master (
        output Start, Sh, ShAmt8, ShIn, CFlagIn,
        input  Busy, Done, ShOut, CarryOut
    );

    modport slave (
        input  Start, Sh, ShAmt8, ShIn, CFlagIn,
        output Busy, Done, ShOut, CarryOut
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM register-specified shifter built from a 1..31 single-pass Shifter.
// Latency accept->Done: 1 (amount 0), 2 (1..31), 3 (32..33); Start is ignored while Busy.

module Shifter (
    input  logic [1:0]  Sh,
    input  logic [4:0]  Shamt5,
    input  logic [31:0] ShIn,
    output logic [31:0] ShOut,
    output logic        CarryOut
);
    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_w;
    logic [5:0]         ror_back;
    logic [31:0]        ror_w;

    // One guard bit beside the operand catches the last bit shifted out.
    always_comb begin
        lsl_w    = {1'b0, ShIn} << Shamt5;
        lsr_w    = {ShIn, 1'b0} >> Shamt5;
        asr_w    = $signed({ShIn, 1'b0}) >>> Shamt5;
        ror_back = 6'd32 - {1'b0, Shamt5};
        ror_w    = (ShIn >> Shamt5) | (ShIn << ror_back);
        case (Sh)
            2'b00: begin
                ShOut    = lsl_w[31:0];
                CarryOut = lsl_w[32];
            end
            2'b01: begin
                ShOut    = lsr_w[32:1];
                CarryOut = lsr_w[0];
            end
            2'b10: begin
                ShOut    = asr_w[32:1];
                CarryOut = asr_w[0];
            end
            default: begin
                ShOut    = ror_w;
                CarryOut = ror_w[31];
            end
        endcase
    end
endmodule

module shift_sequencer (
    input  logic              CLK,
    input  logic              RESET,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] res_q, res_d;
    logic        carry_q, carry_d;
    logic [5:0]  rem_q, rem_d;
    logic [1:0]  sh_q, sh_d;

    logic [4:0]  ror_amt;
    logic [5:0]  eff_amt;
    logic [4:0]  pass_amt;
    logic [5:0]  rem_after;
    logic [31:0] shf_out;
    logic        shf_carry;

    // Rotates wrap to 1..32 so a multiple of 32 still yields a full turn and a carry.
    always_comb begin
        ror_amt = bus.ShAmt8[4:0] - 5'd1;
        eff_amt = 6'd0;
        if (bus.Sh == 2'b11) begin
            if (bus.ShAmt8 != 8'd0) begin
                eff_amt = {1'b0, ror_amt} + 6'd1;
            end
        end else if (bus.ShAmt8 > 8'd33) begin
            eff_amt = 6'd33;
        end else begin
            eff_amt = bus.ShAmt8[5:0];
        end
    end

    // The idle value of 1 keeps the Shifter amount strictly within 1..31.
    always_comb begin
        if (rem_q >= 6'd31) begin
            pass_amt = 5'd31;
        end else if (rem_q == 6'd0) begin
            pass_amt = 5'd1;
        end else begin
            pass_amt = rem_q[4:0];
        end
        rem_after = rem_q - {1'b0, pass_amt};
    end

    Shifter u_shifter (
        .Sh       (sh_q),
        .Shamt5   (pass_amt),
        .ShIn     (res_q),
        .ShOut    (shf_out),
        .CarryOut (shf_carry)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    res_d   = bus.ShIn;
                    carry_d = bus.CFlagIn;
                    sh_d    = bus.Sh;
                    rem_d   = eff_amt;
                    state_d = (eff_amt == 6'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                res_d   = shf_out;
                carry_d = shf_carry;
                rem_d   = rem_after;
                state_d = (rem_after == 6'd0) ? DONE : RUN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rem_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            res_q   <= 32'd0;
            carry_q <= 1'b0;
            rem_q   <= 6'd0;
            sh_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
        end
    end

    assign bus.Busy     = (state_q != IDLE);
    assign bus.Done     = (state_q == DONE);
    assign bus.ShOut    = res_q;
    assign bus.CarryOut = carry_q;
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The module SHALL have exactly one clock, CLK; reset is asynchronous and active-high, RESET.
REQ-002 The module SHALL have these ports, one per line (name  direction  width  meaning):
  CLK  input  1  clock, rising edge active
  RESET  input  1  asynchronous active-high reset
  Start  input  1  request; sampled only in IDLE
  Sh  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR
  ShAmt8  input  8  register-specified shift amount, 0..255
  ShIn  input  32  operand
  CFlagIn  input  1  current C flag
  Busy  output  1  high whenever state is not IDLE
  Done  output  1  one-cycle completion pulse
  ShOut  output  32  registered result, held until the next accepted Start
  CarryOut  output  1  registered carry, held with ShOut
REQ-003 The module SHALL instantiate the existing Shifter block for every pass and drive its Shamt5 only with values 1..31.

Function
REQ-004 The module SHALL implement states IDLE, RUN and DONE, with Busy = (state != IDLE).
REQ-005 In IDLE with Start=1, the module SHALL accept the request at that edge and latch Sh, ShIn and CFlagIn into the working result/carry registers.
REQ-006 On accept, the effective amount SHALL be:
  - LSL/LSR/ASR: min(ShAmt8, 33);
  - ROR: 0 if ShAmt8=0, else ((ShAmt8-1) mod 32)+1.
REQ-007 If the effective amount is 0, the module SHALL go IDLE->DONE with ShOut=ShIn and CarryOut=CFlagIn.
REQ-008 Otherwise the module SHALL enter RUN with remaining = effective amount.
REQ-009 Each RUN cycle SHALL perform one pass of p = min(remaining, 31).
  - The result register takes the Shifter output and the carry register takes the Shifter carry.
  - remaining decrements by p.
  - The next state is DONE when remaining - p = 0, else RUN.
REQ-010 Pass count SHALL be 1 for effective amounts 1..31 and 2 for 32..33; there are never more than 2 passes.
REQ-011 Results SHALL follow ARM register-shift semantics.
  - LSL/LSR by 32: result 0, carry = bit0/bit31 respectively.
  - LSL/LSR by >32: result 0, carry 0.
  - ASR by >=32: result and carry all equal to ShIn[31].
  - ROR by a nonzero multiple of 32: result = ShIn, carry = ShIn[31].
REQ-012 In DONE, Done SHALL be 1 for exactly one cycle, ShOut/CarryOut SHALL hold the final values, and the next state SHALL be IDLE.
REQ-013 Latency from the accept edge to Done high SHALL be 1 cycle for effective amount 0, 2 cycles for 1..31, and 3 cycles for 32..33.
REQ-014 Start while Busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-015 Start held high through DONE SHALL be accepted on the first IDLE cycle; back-to-back requests therefore have at least one IDLE cycle between them.
REQ-016 ShOut and CarryOut SHALL change only at the accept edge and at pass edges, never in IDLE.

Reset
REQ-017 RESET=1 SHALL immediately force state IDLE, Busy=0, Done=0, ShOut=0, CarryOut=0, remaining=0, regardless of the clock.
REQ-018 RESET asserted mid-RUN SHALL abandon the operation with no Done pulse, and the first Start after release SHALL be handled normally.

Verification
REQ-019 LSL, ShIn=0x0A550000, ShAmt8=5, CFlagIn=0 -> ShOut=0x4AA00000, CarryOut=1, Done 2 cycles after accept.
REQ-020 LSR, ShIn=0x00000A55, ShAmt8=4, CFlagIn=1 -> ShOut=0x000000A5, CarryOut=0, Done 2 cycles after accept.
REQ-021 ROR, ShIn=0x12345678, ShAmt8=0, CFlagIn=1 -> ShOut=0x12345678, CarryOut=1, Done 1 cycle after accept.
REQ-022 LSL, ShIn=0x00000001, ShAmt8=32 -> ShOut=0, CarryOut=1. Repeat with ShAmt8=200 -> ShOut=0, CarryOut=0. Both complete with Done 3 cycles after accept.
REQ-023 ASR, ShIn=0x80000000, ShAmt8=40 -> 0xFFFFFFFF with CarryOut=1. ROR, ShIn=0x0000000F, ShAmt8=36 -> 0xF0000000 with CarryOut=1.
REQ-024 Start pulsed during RUN -> ignored. RESET during RUN -> Busy=0, ShOut=0, CarryOut=0, no Done. A new request after release completes correctly.
